// File: rtl/seven_seg_capture.sv
// Loopback decoder for a multiplexed 7-segment display: rebuilds the shown 16-bit hex value.
// Optional SEG_CAP_STATS_EN adds frame_count and glyph_err_count outputs.
module seven_seg_capture #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        changed,
  output logic        bad_glyph,
  output logic        stale
`ifdef SEG_CAP_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [7:0]  glyph_err_count
`endif
);

  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0][3:0] an_sync;
  logic [SYNC_STAGES-1:0][6:0] seg_sync;
  logic [3:0]       sa, sa_q;
  logic [6:0]       ss, ss_q;
  logic [SCW-1:0]   cnt, cnt_next;
  logic [TW-1:0]    tcnt;
  logic [3:0]       seen, seen_next, dig_oh;
  logic [3:0][3:0]  buffer;
  logic [1:0]       dig;
  logic             an_legal, capture, glyph_ok, cap_ok, cap_bad;
  logic             frame_done, timed_out;
  logic [3:0]       nib;

  assign sa = an_sync[SYNC_STAGES-1];
  assign ss = seg_sync[SYNC_STAGES-1];

  always_comb begin
    an_legal = 1'b1;
    dig      = 2'd0;
    case (sa)
      4'b1110: dig = 2'd0;
      4'b1101: dig = 2'd1;
      4'b1011: dig = 2'd2;
      4'b0111: dig = 2'd3;
      default: an_legal = 1'b0;
    endcase
    dig_oh = 4'b0001 << dig;
  end

  // Decoded on the active-high pattern gfedcba.
  always_comb begin
    glyph_ok = 1'b1;
    nib      = 4'h0;
    case (~ss)
      7'h3F: nib = 4'h0;  7'h06: nib = 4'h1;  7'h5B: nib = 4'h2;  7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;  7'h6D: nib = 4'h5;  7'h7D: nib = 4'h6;  7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;  7'h6F: nib = 4'h9;  7'h77: nib = 4'hA;  7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;  7'h5E: nib = 4'hD;  7'h79: nib = 4'hE;  7'h71: nib = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  // Counter saturates one past the capture point so each dwell fires exactly once.
  always_comb begin
    if (!an_legal || sa != sa_q || ss != ss_q) cnt_next = '0;
    else if (cnt == SCW'(STABLE_CYCLES))      cnt_next = cnt;
    else                                      cnt_next = cnt + SCW'(1);
    capture    = an_legal && (cnt_next == SCW'(STABLE_CYCLES - 1));
    cap_ok     = capture && glyph_ok;
    cap_bad    = capture && !glyph_ok;
    frame_done = (seen == 4'hF);
    timed_out  = (tcnt == TW'(TIMEOUT_CYCLES));
    // Frame completion / timeout clear first, so a same-cycle capture starts the next frame.
    seen_next  = ((frame_done || timed_out) ? 4'h0 : seen) | (cap_ok ? dig_oh : 4'h0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_sync     <= '0;
      seg_sync    <= '0;
      sa_q        <= '0;
      ss_q        <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      seen        <= '0;
      buffer      <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      changed     <= 1'b0;
      bad_glyph   <= 1'b0;
      stale       <= 1'b0;
    end else begin
      an_sync     <= {an_sync[SYNC_STAGES-2:0], an_in};
      seg_sync    <= {seg_sync[SYNC_STAGES-2:0], seg_in};
      sa_q        <= sa;
      ss_q        <= ss;
      cnt         <= cnt_next;
      seen        <= seen_next;
      value_valid <= frame_done;
      changed     <= frame_done && (value != buffer);
      if (frame_done) value <= buffer;
      if (cap_ok) buffer[dig] <= nib;
      if (cap_bad) bad_glyph <= 1'b1;
      if (cap_ok)          tcnt <= '0;
      else if (!timed_out) tcnt <= tcnt + TW'(1);
      if (frame_done)     stale <= 1'b0;
      else if (timed_out) stale <= 1'b1;
    end
  end

`ifdef SEG_CAP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count     <= '0;
      glyph_err_count <= '0;
    end else begin
      if (frame_done) frame_count <= frame_count + 16'd1;
      if (cap_bad && glyph_err_count != 8'hFF) glyph_err_count <= glyph_err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture; a scoreboard queue holds expected frames.
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] value;
  logic        value_valid, changed, bad_glyph, stale;
`ifdef SEG_CAP_STATS_EN
  logic [15:0] frame_count;
  logic [7:0]  glyph_err_count;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct { logic [15:0] v; logic ch; } exp_t;
  exp_t sb[$];
  logic [15:0] last_v = 16'h0;

  always #5 clk = ~clk;

  seven_seg_capture #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .value(value), .value_valid(value_valid), .changed(changed),
    .bad_glyph(bad_glyph), .stale(stale)
`ifdef SEG_CAP_STATS_EN
    , .frame_count(frame_count), .glyph_err_count(glyph_err_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Scoreboard: every value_valid pops one expected frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (value_valid) begin
        if (sb.size() == 0) check("unexpected_valid", {16'h0, value}, 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("frame_value", {16'h0, value}, {16'h0, e.v});
          check("frame_changed", {31'h0, changed}, {31'h0, e.ch});
        end
      end else if (changed) begin
        check("changed_without_valid", 32'd1, 32'd0);
      end
    end
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] an_of(input int k);
    logic [3:0] one;
    one = 4'b0001 << k;
    return ~one;
  endfunction

  task automatic expect_frame(input logic [15:0] v);
    exp_t e;
    e.v  = v;
    e.ch = (v != last_v);
    sb.push_back(e);
    last_v = v;
  endtask

  task automatic scan(input logic [15:0] v, input int ndig);
    for (int k = 0; k < ndig; k++) drive(an_of(k), ~glyph(v[4*k +: 4]), 10);
  endtask

  task automatic full_frame(input logic [15:0] v, input string tag);
    expect_frame(v);
    scan(v, 4);
    drive(4'hF, 7'h7F, 4);
    check({tag, "_drained"}, sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; an_in = 4'hF; seg_in = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", {16'h0, value}, 32'h0);
    check("rst_valid", {31'h0, value_valid}, 32'h0);
    check("rst_changed", {31'h0, changed}, 32'h0);
    check("rst_bad", {31'h0, bad_glyph}, 32'h0);
    check("rst_stale", {31'h0, stale}, 32'h0);
    rst = 1'b0;
    drive(4'hF, 7'h7F, 2);

    // Basic frame, then identical frame with changed=0
    full_frame(16'h1234, "f1234");
    full_frame(16'h1234, "f1234_again");

    // Short dwell on digit 2 must not capture
    scan(16'h9876, 2);
    drive(an_of(2), ~glyph(4'h7), 3);
    drive(4'hF, 7'h7F, 10);
    check("short_dwell_no_frame", sb.size(), 32'd0);
    full_frame(16'h9876, "f9876");

    // Illegal glyph on digit 1
    drive(an_of(0), ~glyph(4'h3), 10);
    drive(an_of(1), ~7'h2A, 10);
    drive(4'hF, 7'h7F, 2);
    check("bad_glyph_set", {31'h0, bad_glyph}, 32'd1);
    full_frame(16'hABCD, "fABCD");
    check("bad_glyph_sticky", {31'h0, bad_glyph}, 32'd1);

    // Illegal anodes then long blank -> stale
    check("stale_before", {31'h0, stale}, 32'd0);
    drive(4'b1100, ~glyph(4'h1), 50);
    drive(4'b1111, 7'h7F, 250);
    check("stale_set", {31'h0, stale}, 32'd1);
    check("stale_value_held", {16'h0, value}, 32'h0000_ABCD);
    full_frame(16'h0F0F, "f0F0F");
    check("stale_cleared", {31'h0, stale}, 32'd0);

    // Reset mid-frame discards partial nibbles
    scan(16'hEEEE, 2);
    rst = 1'b1;
    drive(4'hF, 7'h7F, 3);
    check("midrst_value", {16'h0, value}, 32'h0);
    check("midrst_bad", {31'h0, bad_glyph}, 32'h0);
    last_v = 16'h0;
    rst = 1'b0;
    drive(4'hF, 7'h7F, 2);
    expect_frame(16'h5678);
    drive(an_of(0), ~glyph(4'h8), 10);
    drive(an_of(1), ~glyph(4'h7), 10);
    check("postrst_partial_no_frame", {31'h0, value_valid}, 32'd0);
    drive(an_of(2), ~glyph(4'h6), 10);
    drive(an_of(3), ~glyph(4'h5), 10);
    drive(4'hF, 7'h7F, 4);
    check("postrst_drained", sb.size(), 32'd0);
    check("postrst_value", {16'h0, value}, 32'h0000_5678);

    // One illegal glyph plus two more frames (three since reset)
    drive(an_of(2), ~7'h2A, 10);
    full_frame(16'h4321, "f4321");
    full_frame(16'h4321, "f4321_again");
`ifdef SEG_CAP_STATS_EN
    check("frame_count", {16'h0, frame_count}, 32'd3);
    check("glyph_err_count", {24'h0, glyph_err_count}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
